// File: rtl/sobel_edge_pipe.sv
// sobel_edge_pipe: streaming 3x3 Sobel edge detector for a raster pixel stream.
// Two line buffers feed a 3x3 window; a 3-stage free-running pipeline produces
// a saturated gradient magnitude and a thresholded edge bit per interior window.
module sobel_edge_pipe #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned IMG_W   = 160,
    parameter int unsigned IMG_H   = 160,
    parameter int unsigned THR_RST = 170
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_sof,
    input  logic [DATA_W+2:0] thresh,
    input  logic              mode,
    output logic [DATA_W-1:0] dout,
    output logic              dout_edge,
    output logic              dout_valid,
    output logic              frame_done,
    output logic              sof_err
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned SUM_W = DATA_W + 2;
    localparam int unsigned G_W   = DATA_W + 3;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [G_W-1:0]   SAT_MAX  = G_W'((1 << DATA_W) - 1);

    // position counter and latched threshold
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [G_W-1:0]   thr_lat;

    // position of the pixel on din and the counter value that follows it
    logic [COL_W-1:0] pix_col;
    logic [ROW_W-1:0] pix_row;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row_nxt;

    // line buffers: lb1 holds the previous line, lb2 the line before that
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];

    // 3x3 window, index 0 = leftmost column
    logic [DATA_W-1:0] win_t [3];
    logic [DATA_W-1:0] win_m [3];
    logic [DATA_W-1:0] win_b [3];
    logic              w_valid;
    logic              w_last;

    // stage 1: weighted column/row sums
    logic [SUM_W-1:0] sum_r;
    logic [SUM_W-1:0] sum_l;
    logic [SUM_W-1:0] sum_b;
    logic [SUM_W-1:0] sum_t;
    logic [SUM_W-1:0] s1_r;
    logic [SUM_W-1:0] s1_l;
    logic [SUM_W-1:0] s1_b;
    logic [SUM_W-1:0] s1_t;
    logic [G_W-1:0]   s1_thr;
    logic             s1_valid;
    logic             s1_last;

    // stage 2: absolute differences
    logic [SUM_W-1:0] abs_x;
    logic [SUM_W-1:0] abs_y;
    logic [SUM_W-1:0] s2_gx;
    logic [SUM_W-1:0] s2_gy;
    logic [G_W-1:0]   s2_thr;
    logic             s2_valid;
    logic             s2_last;

    // stage 3: magnitude, saturation and threshold compare
    logic [G_W-1:0]    g_sum;
    logic              g_edge;
    logic [DATA_W-1:0] g_mag;

    // SOF forces the current pixel to (0,0); the counter wraps at the frame end
    always_comb begin
        pix_col = din_sof ? '0 : col;
        pix_row = din_sof ? '0 : row;
        col_nxt = pix_col + COL_W'(1);
        row_nxt = pix_row;
        if (pix_col == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (pix_row == ROW_LAST) ? '0 : pix_row + ROW_W'(1);
        end
    end

    // position counter, threshold latch and SOF error pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col     <= '0;
            row     <= '0;
            thr_lat <= G_W'(THR_RST);
            sof_err <= 1'b0;
        end else begin
            sof_err <= din_valid && din_sof && ((col != '0) || (row != '0));
            if (din_valid) begin
                col <= col_nxt;
                row <= row_nxt;
                if (din_sof) begin
                    thr_lat <= thresh;
                end
            end
        end
    end

    // line buffers shift one line down at the accepted column
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
        end else if (din_valid) begin
            lb1[pix_col] <= din;
            lb2[pix_col] <= lb1[pix_col];
        end
    end

    // window shifts left on each accepted pixel; new right column from the buffers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                win_t[k] <= '0;
                win_m[k] <= '0;
                win_b[k] <= '0;
            end
        end else if (din_valid) begin
            for (int k = 0; k < 2; k++) begin
                win_t[k] <= win_t[k+1];
                win_m[k] <= win_m[k+1];
                win_b[k] <= win_b[k+1];
            end
            win_t[2] <= lb2[pix_col];
            win_m[2] <= lb1[pix_col];
            win_b[2] <= din;
        end
    end

    // window tags: pulse only in the cycle after the completing pixel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end else begin
            w_valid <= din_valid && (pix_row >= ROW_W'(2)) && (pix_col >= COL_W'(2));
            w_last  <= din_valid && (pix_row == ROW_LAST) && (pix_col == COL_LAST);
        end
    end

    // Sobel weighted sums: right/left columns for Gx, bottom/top rows for Gy
    always_comb begin
        sum_r = SUM_W'(win_t[2]) + (SUM_W'(win_m[2]) << 1) + SUM_W'(win_b[2]);
        sum_l = SUM_W'(win_t[0]) + (SUM_W'(win_m[0]) << 1) + SUM_W'(win_b[0]);
        sum_b = SUM_W'(win_b[0]) + (SUM_W'(win_b[1]) << 1) + SUM_W'(win_b[2]);
        sum_t = SUM_W'(win_t[0]) + (SUM_W'(win_t[1]) << 1) + SUM_W'(win_t[2]);
    end

    // stage 1 register; the threshold travels with the data across frame changes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_r     <= '0;
            s1_l     <= '0;
            s1_b     <= '0;
            s1_t     <= '0;
            s1_thr   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_r     <= sum_r;
            s1_l     <= sum_l;
            s1_b     <= sum_b;
            s1_t     <= sum_t;
            s1_thr   <= thr_lat;
            s1_valid <= w_valid;
            s1_last  <= w_last;
        end
    end

    // absolute differences
    always_comb begin
        abs_x = (s1_r >= s1_l) ? (s1_r - s1_l) : (s1_l - s1_r);
        abs_y = (s1_b >= s1_t) ? (s1_b - s1_t) : (s1_t - s1_b);
    end

    // stage 2 register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_gx    <= '0;
            s2_gy    <= '0;
            s2_thr   <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_gx    <= abs_x;
            s2_gy    <= abs_y;
            s2_thr   <= s1_thr;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
        end
    end

    // full-width magnitude, saturation and threshold compare
    always_comb begin
        g_sum  = G_W'(s2_gx) + G_W'(s2_gy);
        g_edge = (g_sum > s2_thr);
        g_mag  = (g_sum > SAT_MAX) ? {DATA_W{1'b1}} : g_sum[DATA_W-1:0];
    end

    // output stage; mode is applied here without latching
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout       <= '0;
            dout_edge  <= 1'b0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            dout       <= mode ? g_mag : {DATA_W{g_edge}};
            dout_edge  <= g_edge;
            dout_valid <= s2_valid;
            frame_done <= s2_valid && s2_last;
        end
    end

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// tb_sobel_edge_pipe: table-driven window vectors, directed frame scenarios and
// random frames, all checked against a frame-array reference model.
`timescale 1ns/1ps
module tb_sobel_edge_pipe;

    localparam int unsigned DW   = 8;
    localparam int unsigned IW   = 8;
    localparam int unsigned IH   = 6;
    localparam int unsigned THR0 = 170;
    localparam int unsigned TW   = DW + 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_sof;
    logic [TW-1:0] thresh;
    logic          mode;
    logic [DW-1:0] dout;
    logic          dout_edge;
    logic          dout_valid;
    logic          frame_done;
    logic          sof_err;

    sobel_edge_pipe #(
        .DATA_W (DW),
        .IMG_W  (IW),
        .IMG_H  (IH),
        .THR_RST(THR0)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .thresh    (thresh),
        .mode      (mode),
        .dout      (dout),
        .dout_edge (dout_edge),
        .dout_valid(dout_valid),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // expected result record
    typedef struct {
        int due;
        int g;
        bit edge_b;
        bit last;
        bit md;
    } exp_t;

    // table vector: 3x3 window {p11,p12,p13,p21,p22,p23,p31,p32,p33}
    typedef struct {
        logic [71:0] px;
        int          thr;
        bit          md;
        int          e_dout;
        bit          e_edge;
    } vec_t;

    exp_t eq[$];
    int   sof_q[$];
    vec_t tbl[$];

    int m_col = 0;
    int m_row = 0;
    int m_thr = THR0;
    int img [IH][IW];
    int frm [IH][IW];

    int n_valid, n_done, n_edge, n_ff, n_sof;
    bit want_first, got_first;
    int first_dout;
    bit first_edge;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_cnt();
        n_valid = 0; n_done = 0; n_edge = 0; n_ff = 0; n_sof = 0;
    endtask

    // reference model: store the pixel in a frame image and compute Sobel directly
    task automatic model_accept(input int pix, input bit sof, input int thr_in, input int t, input bit md);
        int r, c, gx, gy;
        exp_t e;
        if (sof) begin
            if (m_col != 0 || m_row != 0) sof_q.push_back(t);
            m_col = 0;
            m_row = 0;
            m_thr = thr_in;
        end
        r = m_row;
        c = m_col;
        img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
            if (gx < 0) gx = -gx;
            if (gy < 0) gy = -gy;
            e.due    = t + 3;
            e.g      = gx + gy;
            e.edge_b = (e.g > m_thr);
            e.last   = (r == IH-1) && (c == IW-1);
            e.md     = md;
            eq.push_back(e);
        end
        m_col++;
        if (m_col == IW) begin
            m_col = 0;
            m_row++;
            if (m_row == IH) m_row = 0;
        end
    endtask

    task automatic model_reset();
        eq.delete();
        sof_q.delete();
        m_col = 0;
        m_row = 0;
        m_thr = THR0;
    endtask

    // drive one accepted pixel, then gap idle cycles
    task automatic send(input int pix, input bit sof, input int gap);
        din       = DW'(pix);
        din_sof   = sof;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        model_accept(pix, sof, int'(thresh), cyc, mode);
        din_valid = 1'b0;
        din_sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap_mode >= 0: fixed gap; < 0: random gap 0..2
    task automatic send_frame(input bit use_sof, input int gap_mode);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                send(frm[r][c], use_sof && r == 0 && c == 0,
                     (gap_mode >= 0) ? gap_mode : int'($urandom_range(0, 2)));
            end
        end
    endtask

    task automatic send_partial(input int npix);
        for (int i = 0; i < npix; i++) begin
            send(frm[i / IW][i % IW], i == 0, 0);
        end
    endtask

    task automatic drain();
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        chk("pending_results", eq.size(), 0);
    endtask

    task automatic fill_step(input int lo, input int hi);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                frm[r][c] = (c < 4) ? lo : hi;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                frm[r][c] = int'($urandom_range(0, (1 << DW) - 1));
    endtask

    task automatic add_vec(input logic [71:0] px, input int thr, input bit md, input int ed, input bit ee);
        vec_t v;
        v.px = px; v.thr = thr; v.md = md; v.e_dout = ed; v.e_edge = ee;
        tbl.push_back(v);
    endtask

    // output monitor: compares every result against the model queue
    exp_t mon_e;
    bit   exp_sof;
    int   exp_dout;
    always @(negedge clk) begin
        if (rstn) begin
            exp_sof = (sof_q.size() > 0) && (sof_q[0] == cyc);
            if (sof_err || exp_sof) begin
                checks++;
                if (sof_err != exp_sof) begin
                    errors++;
                    $display("FAIL sof_err: got %0b expected %0b (t=%0d)", sof_err, exp_sof, cyc);
                end
            end
            if (exp_sof) void'(sof_q.pop_front());
            if (sof_err) n_sof++;
            if (dout_valid) begin
                n_valid++;
                if (frame_done) n_done++;
                if (dout_edge) n_edge++;
                if (dout == {DW{1'b1}}) n_ff++;
                if (want_first && !got_first) begin
                    first_dout = int'(dout);
                    first_edge = dout_edge;
                    got_first  = 1'b1;
                end
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected dout_valid dout=%0d (t=%0d)", dout, cyc);
                end else begin
                    mon_e = eq.pop_front();
                    if (mon_e.md) exp_dout = (mon_e.g > 255) ? 255 : mon_e.g;
                    else          exp_dout = mon_e.edge_b ? 255 : 0;
                    if (int'(dout) != exp_dout || dout_edge != mon_e.edge_b ||
                        frame_done != mon_e.last || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL result: dout=%0d/%0d edge=%0b/%0b frame_done=%0b/%0b t=%0d/%0d (got/expected)",
                                 dout, exp_dout, dout_edge, mon_e.edge_b, frame_done, mon_e.last, cyc, mon_e.due);
                    end
                end
            end else begin
                if (frame_done) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done: got 1 expected 0 without dout_valid (t=%0d)", cyc);
                end
                if (eq.size() > 0 && eq[0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL result: missing output, got none expected g=%0d at t=%0d", eq[0].g, eq[0].due);
                    void'(eq.pop_front());
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; din = '0; din_valid = 1'b0; din_sof = 1'b0;
        thresh = TW'(THR0); mode = 1'b1;
        want_first = 1'b0; got_first = 1'b0; first_dout = 0; first_edge = 1'b0;
        clr_cnt();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                img[r][c] = 0;

        // window vectors: {p11,p12,p13,p21,p22,p23,p31,p32,p33}, thr, mode, dout, edge
        add_vec({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},             0,    1, 0,   0);
        add_vec({8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10},    0,    1, 0,   0);
        add_vec({8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50},          199,  1, 200, 1);
        add_vec({8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50},          200,  1, 200, 0);
        add_vec({8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50},          199,  0, 255, 1);
        add_vec({8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},      1019, 1, 255, 1);
        add_vec({8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},      1020, 0, 0,   0);
        add_vec({8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd255},          509,  1, 255, 1);
        add_vec({8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},          250,  1, 200, 0);
        add_vec({8'd0, 8'd40, 8'd0, 8'd40, 8'd0, 8'd40, 8'd0, 8'd40, 8'd0},        0,    1, 0,   0);
        add_vec({8'd1, 8'd5, 8'd2, 8'd7, 8'd9, 8'd8, 8'd3, 8'd6, 8'd4},            9,    1, 10,  1);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_dout_edge", int'(dout_edge), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_sof_err", int'(sof_err), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // table: first result of each frame is the window centred on (1,1)
        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < IH; r++)
                for (int c = 0; c < IW; c++)
                    frm[r][c] = 0;
            for (int k = 0; k < 9; k++) begin
                logic [71:0] pv;
                pv = tbl[i].px;
                frm[k / 3][k % 3] = int'(pv[8*(8-k) +: 8]);
            end
            thresh = TW'(tbl[i].thr);
            mode   = tbl[i].md;
            want_first = 1'b1;
            got_first  = 1'b0;
            send_frame(1'b1, 0);
            drain();
            want_first = 1'b0;
            chk($sformatf("vec%0d_seen", i), int'(got_first), 1);
            chk($sformatf("vec%0d_dout", i), first_dout, tbl[i].e_dout);
            chk($sformatf("vec%0d_edge", i), int'(first_edge), int'(tbl[i].e_edge));
        end

        // flat frame
        clr_cnt();
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++)
                frm[r][c] = 100;
        thresh = TW'(170); mode = 1'b1;
        send_frame(1'b1, 0);
        drain();
        chk("flat_count", n_valid, 24);
        chk("flat_frame_done", n_done, 1);
        chk("flat_edges", n_edge, 0);

        // vertical step, contiguous
        clr_cnt();
        fill_step(0, 255);
        send_frame(1'b1, 0);
        drain();
        chk("step_count", n_valid, 24);
        chk("step_edges", n_edge, 8);
        chk("step_saturated", n_ff, 8);
        chk("step_frame_done", n_done, 1);

        // vertical step with 1-0-0 valid pattern
        clr_cnt();
        send_frame(1'b1, 2);
        drain();
        chk("gap_count", n_valid, 24);
        chk("gap_edges", n_edge, 8);
        chk("gap_frame_done", n_done, 1);

        // threshold 1020 then 1019 on back-to-back frames, mode 0
        clr_cnt();
        mode = 1'b0;
        thresh = TW'(1020);
        send_frame(1'b1, 0);
        thresh = TW'(1019);
        send_frame(1'b1, 0);
        drain();
        chk("thr_edges", n_edge, 8);
        chk("thr_ff", n_ff, 8);
        chk("thr_frame_done", n_done, 2);

        // mid-frame SOF at pixel (3,2)
        clr_cnt();
        mode = 1'b1;
        thresh = TW'(300);
        fill_rand();
        send_partial(2*IW + 3);
        fill_rand();
        send_frame(1'b1, 0);
        drain();
        chk("abort_sof_err", n_sof, 1);
        chk("abort_count", n_valid, 25);
        chk("abort_frame_done", n_done, 1);

        // reset mid-row 3, then a frame without SOF using the reset threshold
        clr_cnt();
        fill_rand();
        send_partial(3*IW + 5);
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_dout_valid", int'(dout_valid), 0);
        chk("midrst_dout_edge", int'(dout_edge), 0);
        chk("midrst_frame_done", int'(frame_done), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clr_cnt();
        thresh = TW'(1000);
        fill_step(0, 43);
        send_frame(1'b0, 0);
        drain();
        chk("postrst_count", n_valid, 24);
        chk("postrst_edges", n_edge, 8);
        chk("postrst_frame_done", n_done, 1);
        chk("postrst_sof_err", n_sof, 0);

        // random frames with random gaps, threshold and mode
        for (int f = 0; f < 5; f++) begin
            clr_cnt();
            fill_rand();
            thresh = TW'($urandom_range(0, 1100));
            mode   = 1'($urandom_range(0, 1));
            send_frame(1'b1, -1);
            drain();
            chk($sformatf("rand%0d_count", f), n_valid, 24);
            chk($sformatf("rand%0d_frame_done", f), n_done, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
